// File: rtl/stream_sink_pkg.sv
// stream_sink_pkg: shared FSM state encoding and default sizing for stream_sink
package stream_sink_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/stream_sink_if.sv
// stream_sink_if: byte-stream handshake (tdata/tvalid/tready/tlast) between a source and stream_sink
interface stream_sink_if
    import stream_sink_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/stream_sink_fifo.sv
// stream_sink_fifo: circular RAM with wrapping pointers and registered count/empty/full
module stream_sink_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d, full_q, full_d;

    // next pointers wrap naturally at DEPTH; flags derive from the next count
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        empty_d = count_d == '0;
        full_d  = count_d == CNT_W'(DEPTH);
    end

    // pointer and occupancy registers; stored data is abandoned on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // storage array needs no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata      = mem_q[rptr_q];
    assign count      = count_q;
    assign count_next = count_d;
    assign empty      = empty_q;
    assign full       = full_q;

endmodule

// File: rtl/stream_sink.sv
// stream_sink: frame-aware stream receiver feeding a byte-at-a-time consumer.
// Optional STREAM_SINK_FRAME_LEN_EN adds frame_len, the saturating beat count of the held frame.
module stream_sink
    import stream_sink_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    stream_sink_if.slave      s,
    input  logic              pop,
    output logic [DATA_W-1:0] Dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic [CNT_W-1:0]  buff_count,
    output logic              empty,
    output logic              full,
    output logic              frame_done
`ifdef STREAM_SINK_FRAME_LEN_EN
    ,
    output logic [CNT_W+3:0]  frame_len
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e            state_q, state_d;
    logic              tready_q, tready_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;
    logic              frame_done_q, frame_done_d;
    logic              accept, do_pop, fifo_empty;
    logic [DATA_W:0]   rdata;
    logic [CNT_W-1:0]  count_next;

    assign accept = s.tvalid && tready_q;
    assign do_pop = pop && !fifo_empty;

    stream_sink_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .pop        (do_pop),
        .wdata      ({s.tlast, s.tdata}),
        .rdata      (rdata),
        .count      (buff_count),
        .count_next (count_next),
        .empty      (fifo_empty),
        .full       (full)
    );

    // frame FSM, registered tready (drops before the FIFO can overflow) and one-cycle pop response
    always_comb begin
        state_d      = (state_q == IDLE) ? RECV :
                       (state_q == RECV && accept && s.tlast) ? HOLD :
                       (state_q == HOLD && count_next == '0) ? RECV : state_q;
        tready_d     = state_q == RECV && count_next < DEPTH_C && !(accept && s.tlast);
        dout_valid_d = do_pop;
        dout_d       = do_pop ? rdata[DATA_W-1:0] : dout_q;
        dout_last_d  = do_pop && rdata[DATA_W];
        frame_done_d = state_d == HOLD;
    end

    // control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tready_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef STREAM_SINK_FRAME_LEN_EN
    logic [CNT_W+3:0] frame_len_q, frame_len_d;

    // beats in the current frame; frozen through HOLD, cleared when receiving restarts
    always_comb begin
        frame_len_d = (state_q != RECV && state_d == RECV) ? '0 :
                      (accept && ~&frame_len_q) ? frame_len_q + 1'b1 : frame_len_q;
    end

    // frame length register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_len_q <= '0;
        else      frame_len_q <= frame_len_d;
    end

    assign frame_len = frame_len_q;
`endif

    assign s.tready   = tready_q;
    assign Dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign empty      = fifo_empty;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stream_sink.sv
// tb_stream_sink: randomized self-checking bench for stream_sink against a queue-based frame model
module tb_stream_sink;

    localparam int DEPTH   = 16;
    localparam int LEN_MAX = 511;

    logic       clk, rst, pop;
    logic [7:0] Dout;
    logic       dout_valid, dout_last, empty, full, frame_done;
    logic [4:0] buff_count;
`ifdef STREAM_SINK_FRAME_LEN_EN
    logic [8:0] frame_len;
`endif

    stream_sink_if #(.DATA_W(8)) s_if ();

    stream_sink #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s_if),
        .pop        (pop),
        .Dout       (Dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .buff_count (buff_count),
        .empty      (empty),
        .full       (full),
        .frame_done (frame_done)
`ifdef STREAM_SINK_FRAME_LEN_EN
        ,
        .frame_len  (frame_len)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [8:0] q[$];
    bit         m_ready, m_hold, m_started, m_dv, m_dl;
    logic [7:0] m_dout;
    int         m_len;

    task automatic model_reset();
        q.delete();
        m_ready = 0; m_hold = 0; m_started = 0; m_dv = 0; m_dl = 0;
        m_dout = 8'h00; m_len = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit p);
        bit acc, pk, hold_before, recv_before;
        logic [8:0] e;
        s_if.tvalid = v; s_if.tdata = d; s_if.tlast = l; pop = p;
        acc         = v && m_ready;
        pk          = p && q.size() != 0;
        hold_before = m_hold;
        recv_before = m_started && !m_hold;
        @(posedge clk); #1;
        m_dv = pk; m_dl = 0;
        if (pk) begin
            e = q.pop_front();
            m_dout = e[7:0];
            m_dl = e[8];
        end
        if (acc) begin
            q.push_back({l, d});
            if (m_len < LEN_MAX) m_len++;
        end
        if (acc && l) m_hold = 1;
        else if (hold_before && q.size() == 0) begin
            m_hold = 0;
            m_len = 0;
        end
        m_ready   = recv_before && q.size() < DEPTH && !(acc && l);
        m_started = 1;
        s_if.tvalid = 0; pop = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
    endtask

    task automatic test_reset();
        rst = 0; pop = 0; s_if.tvalid = 0; s_if.tdata = 8'h00; s_if.tlast = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_if.tready, empty, full, buff_count, dout_valid, dout_last, Dout, frame_done} !==
            {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_state: got tready=%b empty=%b full=%b cnt=%0d dv=%b dl=%b dout=%h fd=%b, need 0 1 0 0 0 0 00 0",
                     s_if.tready, empty, full, buff_count, dout_valid, dout_last, Dout, frame_done);
        else passed++;
        rst = 1;
        step(0, 8'h00, 0, 0);
        checks++;
        if ({s_if.tready, empty} !== 2'b01) $display("FAIL first_cycle: got tready=%b empty=%b need 0 1", s_if.tready, empty);
        else passed++;
        step(0, 8'h00, 0, 0);
        checks++;
        if (s_if.tready !== 1'b1) $display("FAIL second_cycle_tready: got %b need 1", s_if.tready);
        else passed++;
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_d[3] = '{8'hA1, 8'hB2, 8'hC3};
        for (int i = 0; i < 3; i++) step(1, exp_d[i], i == 2, 0);
        checks++;
        if ({buff_count, frame_done, s_if.tready} !== {5'd3, 1'b1, 1'b0})
            $display("FAIL frame_stored: got cnt=%0d fd=%b tready=%b need 3 1 0", buff_count, frame_done, s_if.tready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, 1);
            checks++;
            if ({dout_valid, Dout, dout_last} !== {1'b1, exp_d[i], i == 2})
                $display("FAIL basic_pop%0d: got dv=%b dout=%h dl=%b need 1 %h %b", i, dout_valid, Dout, dout_last, exp_d[i], i == 2);
            else passed++;
        end
        checks++;
        if ({empty, frame_done} !== 2'b10) $display("FAIL frame_drained: got empty=%b fd=%b need 1 0", empty, frame_done);
        else passed++;
        step(0, 8'h00, 0, 0);
        checks++;
        if ({s_if.tready, dout_valid, Dout} !== {1'b1, 1'b0, 8'hC3})
            $display("FAIL ready_again: got tready=%b dv=%b dout=%h need 1 0 c3", s_if.tready, dout_valid, Dout);
        else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
        checks++;
        if ({full, buff_count, s_if.tready} !== {1'b1, 5'd16, 1'b0})
            $display("FAIL full_state: got full=%b cnt=%0d tready=%b need 1 16 0", full, buff_count, s_if.tready);
        else passed++;
        step(1, 8'h55, 0, 0);
        step(1, 8'h55, 0, 0);
        checks++;
        if ({buff_count, s_if.tready} !== {5'd16, 1'b0})
            $display("FAIL held_beat: got cnt=%0d tready=%b need 16 0", buff_count, s_if.tready);
        else passed++;
        step(1, 8'h55, 0, 1);
        checks++;
        if ({buff_count, Dout, dout_valid, s_if.tready} !== {5'd15, 8'h40, 1'b1, 1'b1})
            $display("FAIL pop_when_full: got cnt=%0d dout=%h dv=%b tready=%b need 15 40 1 1", buff_count, Dout, dout_valid, s_if.tready);
        else passed++;
        step(1, 8'h55, 0, 0);
        checks++;
        if ({buff_count, full} !== {5'd16, 1'b1}) $display("FAIL beat17_accept: got cnt=%0d full=%b need 16 1", buff_count, full);
        else passed++;
        for (int i = 1; i < 17; i++) begin
            step(0, 8'h00, 0, 1);
            checks++;
            if (Dout !== (i == 16 ? 8'h55 : 8'(8'h40 + i))) $display("FAIL full_drain%0d: got %h need %h", i, Dout, i == 16 ? 8'h55 : 8'(8'h40 + i));
            else passed++;
        end
        drain();
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1, 8'(r * 10 + i), 0, 0);
            for (int i = 0; i < 10; i++) begin
                step(0, 8'h00, 0, 1);
                checks++;
                if ({dout_valid, Dout} !== {1'b1, 8'(r * 10 + i)}) $display("FAIL wrap_r%0d_i%0d: got dv=%b dout=%h need 1 %h", r, i, dout_valid, Dout, 8'(r * 10 + i));
                else passed++;
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'($urandom), 0, 1);
            checks++;
            if ({buff_count, dout_valid, Dout} !== {5'd5, 1'b1, m_dout})
                $display("FAIL push_pop%0d: got cnt=%0d dv=%b dout=%h need 5 1 %h", i, buff_count, dout_valid, Dout, m_dout);
            else passed++;
        end
        drain();
    endtask

    task automatic test_frame_len();
`ifdef STREAM_SINK_FRAME_LEN_EN
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), i == 4, 0);
        checks++;
        if ({frame_len, frame_done} !== {9'd5, 1'b1}) $display("FAIL frame_len: got len=%0d fd=%b need 5 1", frame_len, frame_done);
        else passed++;
        drain();
        checks++;
        if (frame_len !== 9'd0) $display("FAIL frame_len_clear: got %0d need 0", frame_len);
        else passed++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if ({s_if.tready, buff_count, empty, full, frame_done, dout_valid, Dout} !==
                {m_ready, 5'(q.size()), q.size() == 0, q.size() == DEPTH, m_hold, m_dv, m_dout})
                $display("FAIL random%0d: got tready=%b cnt=%0d e=%b f=%b fd=%b dv=%b dout=%h need %b %0d %b %b %b %b %h",
                         i, s_if.tready, buff_count, empty, full, frame_done, dout_valid, Dout,
                         m_ready, q.size(), q.size() == 0, q.size() == DEPTH, m_hold, m_dv, m_dout);
            else passed++;
            if (m_dv) begin
                checks++;
                if (dout_last !== m_dl) $display("FAIL random_last%0d: got %b need %b", i, dout_last, m_dl);
                else passed++;
            end
`ifdef STREAM_SINK_FRAME_LEN_EN
            checks++;
            if (frame_len !== 9'(m_len)) $display("FAIL random_len%0d: got %0d need %0d", i, frame_len, m_len);
            else passed++;
`endif
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0, i == 6);
        step(1, 8'($urandom), 0, 0);
        checks++;
        if (buff_count !== 5'd7) $display("FAIL pre_reset_count: got %0d need 7", buff_count);
        else passed++;
        rst = 0;
        #2;
        checks++;
        if ({s_if.tready, empty, full, buff_count, dout_valid, dout_last, Dout, frame_done} !==
            {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL async_reset: got tready=%b empty=%b full=%b cnt=%0d dv=%b dl=%b dout=%h fd=%b, need 0 1 0 0 0 0 00 0",
                     s_if.tready, empty, full, buff_count, dout_valid, dout_last, Dout, frame_done);
        else passed++;
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'h9E, 1, 0);
        step(0, 8'h00, 0, 1);
        checks++;
        if ({dout_valid, Dout, dout_last, empty} !== {1'b1, 8'h9E, 1'b1, 1'b1})
            $display("FAIL post_reset_frame: got dv=%b dout=%h dl=%b empty=%b need 1 9e 1 1", dout_valid, Dout, dout_last, empty);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_full();
        test_wrap();
        test_back_to_back();
        test_frame_len();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
